// File: rtl/alsu_pkg.sv
// Shared opcodes, decode kinds and blinker states for the handshaked ALSU.
// Decode priority: invalid, then bypass, then reduction, then plain opcode.
package alsu_pkg;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_XOR   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;
   localparam logic [2:0] OP_SHIFT = 3'b100;
   localparam logic [2:0] OP_ROT   = 3'b101;

   typedef enum logic [2:0] {
      K_INVALID, K_BYP_A, K_BYP_B, K_RED_A, K_RED_B, K_OP
   } kind_e;

   typedef enum logic {BL_IDLE, BL_BLINK} blink_st_e;

   function automatic kind_e decode_kind(input logic [2:0] op,
                                         input logic red_a, input logic red_b,
                                         input logic byp_a, input logic byp_b,
                                         input logic prio_b);
      // Reductions only exist for AND/XOR; opcodes 11x are unassigned.
      if (((red_a || red_b) && op != OP_AND && op != OP_XOR) || op[2:1] == 2'b11)
         return K_INVALID;
      if (byp_a && byp_b) return prio_b ? K_BYP_B : K_BYP_A;
      if (byp_a)          return K_BYP_A;
      if (byp_b)          return K_BYP_B;
      if (red_a && red_b) return prio_b ? K_RED_B : K_RED_A;
      if (red_a)          return K_RED_A;
      if (red_b)          return K_RED_B;
      return K_OP;
   endfunction

endpackage

// File: rtl/alsu_if.sv
// Operand-bundle and result handshake bundle between sequencer, ALSU and consumer.
interface alsu_if #(
   parameter int WIDTH = 3,
   parameter int LED_W = 16
);
   localparam int OW = 2 * WIDTH;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       opcode;
   logic             cin;
   logic             serial_in;
   logic             direction;
   logic             red_op_A;
   logic             red_op_B;
   logic             bypass_A;
   logic             bypass_B;
   logic             out_valid;
   logic             out_ready;
   logic [OW-1:0]    out;
   logic             invalid;
   logic [LED_W-1:0] leds;

   modport slave (
      input  in_valid, A, B, opcode, cin, serial_in, direction,
             red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
      output in_ready, out_valid, out, invalid, leds
   );

   modport master (
      output in_valid, A, B, opcode, cin, serial_in, direction,
             red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
      input  in_ready, out_valid, out, invalid, leds
   );

endinterface

// File: rtl/alsu_led_blinker.sv
// Alarm LED pattern: all-ones on start, inverted every BLINK_PERIOD cycles, cleared on clear.
// A start while already blinking keeps the running phase.
module alsu_led_blinker
   import alsu_pkg::*;
#(
   parameter int LED_W        = 16,
   parameter int BLINK_PERIOD = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             clear_i,
   output logic [LED_W-1:0] leds_o
);

   localparam int            CW   = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_PERIOD - 1);

   blink_st_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [LED_W-1:0] leds_q, leds_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= BL_IDLE;
         cnt_q   <= '0;
         leds_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         leds_q  <= leds_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      leds_d  = leds_q;
      case (state_q)
         BL_IDLE: begin
            if (start_i) begin
               state_d = BL_BLINK;
               cnt_d   = '0;
               leds_d  = '1;
            end
         end
         BL_BLINK: begin
            if (clear_i) begin
               state_d = BL_IDLE;
               cnt_d   = '0;
               leds_d  = '0;
            end else if (cnt_q == LAST) begin
               cnt_d  = '0;
               leds_d = ~leds_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = BL_IDLE;
      endcase
   end

   assign leds_o = leds_q;

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage handshaked ALSU: capture register, then compute into the held result register.
// Result visible two cycles after the accept cycle; a stalled output backs up into stage 1.
module alsu_pipe
   import alsu_pkg::*;
#(
   parameter int    WIDTH          = 3,
   parameter string INPUT_PRIORITY = "A",
   parameter string FULL_ADDER     = "ON",
   parameter int    LED_W          = 16,
   parameter int    BLINK_PERIOD   = 4
) (
   input  logic  clk_i,
   input  logic  rst_i,
   alsu_if.slave bus
);

   localparam int OW     = 2 * WIDTH;
   localparam bit PRIO_B = (INPUT_PRIORITY == "B");
   localparam bit FA_ON  = (FULL_ADDER == "ON");

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
      logic             cin;
      logic             si;
      logic             dir;
      logic             red_a;
      logic             red_b;
      logic             byp_a;
      logic             byp_b;
   } bundle_t;

   bundle_t          in_bundle, s1_q;
   logic             s1_full_q, out_valid_q, invalid_q;
   logic [OW-1:0]    out_q, out_d;
   logic             s2_load, accept;
   kind_e            kind;
   logic [WIDTH:0]   sum;
   logic [OW-1:0]    prod;
   logic [WIDTH-1:0] red_src;

   assign in_bundle = '{a: bus.A, b: bus.B, op: bus.opcode, cin: bus.cin,
                        si: bus.serial_in, dir: bus.direction,
                        red_a: bus.red_op_A, red_b: bus.red_op_B,
                        byp_a: bus.bypass_A, byp_b: bus.bypass_B};

   assign s2_load      = s1_full_q && (!out_valid_q || bus.out_ready);
   assign bus.in_ready = !s1_full_q || s2_load;
   assign accept       = bus.in_valid && bus.in_ready;

   assign kind = decode_kind(s1_q.op, s1_q.red_a, s1_q.red_b, s1_q.byp_a, s1_q.byp_b, PRIO_B);

   always_comb begin
      red_src = (kind == K_RED_B) ? s1_q.b : s1_q.a;
      sum     = {1'b0, s1_q.a} + {1'b0, s1_q.b} + {{WIDTH{1'b0}}, FA_ON && s1_q.cin};
      prod    = OW'(s1_q.a) * OW'(s1_q.b);
      out_d   = '0;
      case (kind)
         K_BYP_A: out_d = OW'(s1_q.a);
         K_BYP_B: out_d = OW'(s1_q.b);
         K_RED_A, K_RED_B: out_d = (s1_q.op == OP_AND) ? OW'(&red_src) : OW'(^red_src);
         K_OP: begin
            case (s1_q.op)
               OP_AND: out_d = OW'(s1_q.a & s1_q.b);
               OP_XOR: out_d = OW'(s1_q.a ^ s1_q.b);
               OP_ADD: out_d = OW'(sum);
               OP_MUL: out_d = prod;
               // Shift/rotate work on the held result so consecutive requests chain.
               OP_SHIFT: out_d = s1_q.dir ? {out_q[OW-2:0], s1_q.si} : {s1_q.si, out_q[OW-1:1]};
               OP_ROT:   out_d = s1_q.dir ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
               default:  out_d = '0;
            endcase
         end
         default: out_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_full_q   <= 1'b0;
         s1_q        <= '0;
         out_q       <= '0;
         invalid_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            s1_q      <= in_bundle;
            s1_full_q <= 1'b1;
         end else if (s2_load) begin
            s1_full_q <= 1'b0;
         end
         if (s2_load) begin
            out_q       <= out_d;
            invalid_q   <= (kind == K_INVALID);
            out_valid_q <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   alsu_led_blinker #(
      .LED_W       (LED_W),
      .BLINK_PERIOD(BLINK_PERIOD)
   ) u_blinker (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(s2_load && (kind == K_INVALID)),
      .clear_i(s2_load && (kind != K_INVALID)),
      .leds_o (bus.leds)
   );

   assign bus.out       = out_q;
   assign bus.invalid   = invalid_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Drives three ALSU configurations (default, FULL_ADDER OFF, INPUT_PRIORITY B) with one stimulus
// stream and checks them against an in-order result model plus literal expectations.
module tb_alsu_pipe;

   localparam int W  = 3;
   localparam int OW = 6;
   localparam int LW = 16;
   localparam int P  = 4;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic [W-1:0] a = '0, b = '0;
   logic [2:0] op = '0;
   logic cin = 1'b0, si = 1'b0, dir = 1'b0, ra = 1'b0, rb = 1'b0, ba = 1'b0, bb = 1'b0;

   logic [OW-1:0] o_out  [ND];
   logic          o_vld  [ND];
   logic          o_inv  [ND];
   logic          o_rdy  [ND];
   logic [LW-1:0] o_leds [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      alsu_if #(.WIDTH(W), .LED_W(LW)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.A         = a;
      assign bus.B         = b;
      assign bus.opcode    = op;
      assign bus.cin       = cin;
      assign bus.serial_in = si;
      assign bus.direction = dir;
      assign bus.red_op_A  = ra;
      assign bus.red_op_B  = rb;
      assign bus.bypass_A  = ba;
      assign bus.bypass_B  = bb;
      assign bus.out_ready = out_ready;
      assign o_out[g]  = bus.out;
      assign o_vld[g]  = bus.out_valid;
      assign o_inv[g]  = bus.invalid;
      assign o_rdy[g]  = bus.in_ready;
      assign o_leds[g] = bus.leds;

      alsu_pipe #(
         .WIDTH         (W),
         .INPUT_PRIORITY(g == 2 ? "B" : "A"),
         .FULL_ADDER    (g == 1 ? "OFF" : "ON"),
         .LED_W         (LW),
         .BLINK_PERIOD  (P)
      ) dut (
         .clk_i(clk),
         .rst_i(rst),
         .bus  (bus)
      );
   end

   int npass = 0, ntot = 0, cyc = 0;
   bit acc_flag;
   int obs_q[$];
   // Expected results per DUT, encoded as {invalid, out[5:0]}.
   int expq[ND][$];
   int mout[ND];
   bit alarm[ND];
   int astart[ND];
   bit pvld[ND], phs[ND];
   int hval[ND];
   int tv[8][4];

   task automatic chk(input string nm, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   // Result of the bundle currently on the inputs for configuration g, given the prior result.
   function automatic int calc(input int g, input int prev);
      int sel;
      int av = int'(a);
      int bv = int'(b);
      bit pb = (g == 2);
      bit fa = (g != 1);
      if (((ra || rb) && op > 1) || op >= 6) return 64;
      if (ba || bb) begin
         sel = (ba && bb) ? (pb ? bv : av) : (ba ? av : bv);
         return sel;
      end
      if (ra || rb) begin
         sel = (ra && rb) ? (pb ? bv : av) : (ra ? av : bv);
         if (op == 0) return (sel == 7) ? 1 : 0;
         return $countones(sel) % 2;
      end
      case (op)
         3'd0: return av & bv;
         3'd1: return av ^ bv;
         3'd2: return av + bv + (fa ? int'(cin) : 0);
         3'd3: return av * bv;
         3'd4: return dir ? (((prev * 2) + int'(si)) % 64) : ((int'(si) * 32) + (prev / 2));
         3'd5: return dir ? (((prev * 2) % 64) + (prev / 32)) : (((prev % 2) * 32) + (prev / 2));
         default: return 64;
      endcase
   endfunction

   task monitor;
      acc_flag = 1'b0;
      for (int g = 0; g < ND; g++) begin
         int cur;
         int e;
         int lexp;
         cur = int'({o_inv[g], o_out[g]});
         if (rst) begin
            chk($sformatf("reset_state_dut%0d", g),
                int'({o_vld[g], o_inv[g], o_out[g], o_leds[g]}), 0);
            expq[g].delete();
            mout[g] = 0; alarm[g] = 1'b0; pvld[g] = 1'b0; phs[g] = 1'b0;
         end else begin
            if (o_vld[g] && (!pvld[g] || phs[g])) begin
               if (expq[g].size() == 0) begin
                  ntot++;
                  $display("FAIL spurious_result_dut%0d: got %0d, want no result", g, cur);
               end else begin
                  e = expq[g].pop_front();
                  chk($sformatf("result_dut%0d", g), cur, e);
                  if (e >= 64) begin
                     if (!alarm[g]) begin alarm[g] = 1'b1; astart[g] = cyc; end
                  end else alarm[g] = 1'b0;
                  if (g == 0) obs_q.push_back(cur % 64);
               end
            end else if (pvld[g] && !phs[g]) begin
               chk($sformatf("hold_dut%0d", g), o_vld[g] ? cur : -1, hval[g]);
            end
            lexp = (alarm[g] && (((cyc - astart[g]) / P) % 2 == 0)) ? 'hFFFF : 0;
            chk($sformatf("leds_dut%0d", g), int'(o_leds[g]), lexp);
            if (in_valid && o_rdy[g]) begin
               e = calc(g, mout[g]);
               expq[g].push_back(e);
               mout[g] = e % 64;
               if (g == 0) acc_flag = 1'b1;
            end
            pvld[g] = o_vld[g];
            phs[g]  = o_vld[g] && out_ready;
            hval[g] = cur;
         end
      end
   endtask

   task step;
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // flags: [0] cin, [1] serial_in, [2] direction, [3] red_A, [4] red_B, [5] byp_A, [6] byp_B
   task automatic set_in(input int o, input int ia, input int ib, input int f);
      op = o[2:0]; a = ia[2:0]; b = ib[2:0];
      cin = f[0]; si = f[1]; dir = f[2]; ra = f[3]; rb = f[4]; ba = f[5]; bb = f[6];
   endtask

   task send;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (acc_flag) break;
      end
      if (!acc_flag) begin
         ntot++;
         $display("FAIL send_timeout: got no accept, want accept within 20 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic run1(input string nm, input int e0, input int e1, input int e2, input int einv);
      send();
      chk({nm, "_early_valid"}, int'(o_vld[0]), 0);
      step();
      chk({nm, "_valid"}, int'(o_vld[0]), 1);
      chk({nm, "_out0"}, int'(o_out[0]), e0);
      chk({nm, "_out1"}, int'(o_out[1]), e1);
      chk({nm, "_out2"}, int'(o_out[2]), e2);
      chk({nm, "_invalid"}, int'(o_inv[0]), einv);
   endtask

   initial begin
      int idx;
      tv = '{'{4, 0, 0, 6}, '{4, 0, 0, 6}, '{5, 0, 0, 4}, '{2, 3, 4, 1},
             '{3, 5, 6, 0}, '{1, 5, 3, 0}, '{5, 0, 0, 0}, '{4, 0, 0, 2}};
      #1 rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("in_ready_after_reset", int'(o_rdy[0]), 1);

      set_in(2, 7, 5, 1);    run1("add", 13, 12, 13, 0);
      set_in(3, 7, 7, 0);    run1("mul", 49, 49, 49, 0);
      set_in(1, 6, 7, 8);    run1("redxor_a", 0, 0, 0, 0);
      set_in(0, 7, 2, 8);    run1("redand_a", 1, 1, 1, 0);
      set_in(1, 1, 3, 24);   run1("red_both", 1, 1, 0, 0);
      set_in(2, 5, 5, 16);   run1("red_add_inv", 0, 0, 0, 1);
      set_in(0, 6, 3, 0);    run1("and_clear", 2, 2, 2, 0);
      chk("leds_cleared", int'(o_leds[0]), 0);

      set_in(6, 1, 1, 0);    run1("op110", 0, 0, 0, 1);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("blink_k%0d", k), int'(o_leds[0]), (k % 8 < 4) ? 'hFFFF : 0);
         step();
      end
      set_in(7, 1, 1, 0);    run1("op111", 0, 0, 0, 1);
      chk("blink_no_restart", int'(o_leds[0]), 0);
      set_in(0, 6, 3, 0);    run1("and_after_alarm", 2, 2, 2, 0);
      chk("leds_after_valid", int'(o_leds[0]), 0);

      set_in(0, 2, 5, 96);   run1("bypass_both", 2, 2, 5, 0);
      set_in(0, 1, 6, 32);   run1("bypass_a", 1, 1, 1, 0);
      set_in(4, 0, 0, 6);    run1("shift_left", 3, 3, 3, 0);
      set_in(5, 0, 0, 0);    run1("rotate_right", 33, 33, 33, 0);
      set_in(4, 0, 0, 0);    run1("shift_right", 16, 16, 16, 0);

      // Back-to-back stream with an intermittently stalled consumer.
      idx = 0;
      for (int k = 0; k < 60 && idx < 8; k++) begin
         out_ready = (k % 3 != 2);
         set_in(tv[idx][0], tv[idx][1], tv[idx][2], tv[idx][3]);
         in_valid = 1'b1;
         step();
         if (acc_flag) idx++;
      end
      chk("stream_accepted", idx, 8);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();

      // Consumer blocked: only two bundles fit, output frozen.
      obs_q.delete();
      out_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 8; k++) begin
         set_in(2, idx + 1, 1, 0);
         in_valid = 1'b1;
         step();
         if (acc_flag) idx++;
      end
      chk("bp_accepted", idx, 2);
      chk("bp_in_ready", int'(o_rdy[0]), 0);
      chk("bp_out_frozen", int'(o_out[0]), 2);
      out_ready = 1'b1;
      for (int k = 0; k < 20 && idx < 4; k++) begin
         set_in(2, idx + 1, 1, 0);
         in_valid = 1'b1;
         step();
         if (acc_flag) idx++;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("bp_count", obs_q.size(), 4);
      for (int k = 0; k < 4 && k < obs_q.size(); k++)
         chk($sformatf("bp_order%0d", k), obs_q[k], k + 2);

      // Reset with bundles in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_in(3, k + 2, 3, 0);
         in_valid = 1'b1;
         step();
      end
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", int'(o_vld[0]), 0);
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      obs_q.delete();
      for (int k = 0; k < 6; k++) step();
      chk("no_stale_result", obs_q.size(), 0);
      chk("in_ready_after_mid_rst", int'(o_rdy[0]), 1);
      set_in(4, 0, 0, 6);    run1("shift_after_rst", 1, 1, 1, 0);
      set_in(2, 1, 1, 0);    run1("add_after_rst", 2, 2, 2, 0);
      step();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
